// File: rtl/alu_issue_stage.sv
// Operand-issue register stage for the BETA ALU. It decodes the opcode into a unit, a function
// code and operand B, and holds the result behind a valid/ready output. ALU_ISSUE_SKID_EN adds a skid register.
module alu_issue_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTR,
    input  logic [31:0] RA_DATA,
    input  logic [31:0] RB_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [1:0]  UNIT,
    output logic [3:0]  FN,
    output logic [4:0]  RC,
    output logic        ILLEGAL
);

    // Handshakes: a transfer happens on a rising edge when valid and ready are both high.
    // IN_READY comes only from stored occupancy, so it never depends on OUT_READY or IN_VALID.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  unit;
        logic [3:0]  fn;
        logic [4:0]  rc;
        logic        illegal;
    } entry_t;

    logic [5:0] w_opc;
    entry_t     w_dec;
    logic       w_push;
    logic       w_pop;
    entry_t     r_main;
    logic       r_main_valid;

    assign w_opc = INSTR[31:26];

    always_comb begin
        w_dec         = '0;
        w_dec.a       = RA_DATA;
        w_dec.b       = w_opc[4] ? {{16{INSTR[15]}}, INSTR[15:0]} : RB_DATA;
        w_dec.rc      = INSTR[25:21];
        w_dec.unit    = 2'b10;
        w_dec.fn      = 4'b0000;
        w_dec.illegal = 1'b1;
        // Illegal opcodes go to BOOL with a zero function code, so the ALU produces 0.
        if (w_opc[5]) begin
            w_dec.illegal = 1'b0;
            case (w_opc[3:0])
                4'h0: begin w_dec.unit = 2'b00; w_dec.fn = 4'b0000; end
                4'h1: begin w_dec.unit = 2'b00; w_dec.fn = 4'b0001; end
                4'h2: begin w_dec.unit = 2'b00; w_dec.fn = 4'b0010; end
                4'h3: begin w_dec.unit = 2'b00; w_dec.fn = 4'b0011; end
                4'h4: begin w_dec.unit = 2'b01; w_dec.fn = 4'b0011; end
                4'h5: begin w_dec.unit = 2'b01; w_dec.fn = 4'b0101; end
                4'h6: begin w_dec.unit = 2'b01; w_dec.fn = 4'b0111; end
                4'h8: begin w_dec.unit = 2'b10; w_dec.fn = 4'b1000; end
                4'h9: begin w_dec.unit = 2'b10; w_dec.fn = 4'b1110; end
                4'hA: begin w_dec.unit = 2'b10; w_dec.fn = 4'b0110; end
                4'hC: begin w_dec.unit = 2'b11; w_dec.fn = 4'b0000; end
                4'hD: begin w_dec.unit = 2'b11; w_dec.fn = 4'b0001; end
                4'hE: begin w_dec.unit = 2'b11; w_dec.fn = 4'b0011; end
                default: begin
                    w_dec.illegal = 1'b1;
                    w_dec.unit    = 2'b10;
                    w_dec.fn      = 4'b0000;
                end
            endcase
        end
    end

    assign w_push = IN_VALID & IN_READY;
    assign w_pop  = r_main_valid & OUT_READY;

`ifdef ALU_ISSUE_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;

    assign IN_READY = ~r_skid_valid;

    // Skid only fills when main is held and not consumed, and it always drains into main first.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (FLUSH) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_pop) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_push;
                if (w_push) begin
                    r_main <= w_dec;
                end
            end
        end else if (w_push) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign IN_READY = ~r_main_valid;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
        end else if (FLUSH) begin
            r_main_valid <= 1'b0;
        end else if (w_push) begin
            r_main       <= w_dec;
            r_main_valid <= 1'b1;
        end else if (w_pop) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

    assign OUT_VALID = r_main_valid;
    assign A         = r_main.a;
    assign B         = r_main.b;
    assign UNIT      = r_main.unit;
    assign FN        = r_main.fn;
    assign RC        = r_main.rc;
    assign ILLEGAL   = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a decode-table model feeds an expected queue
// that follows occupancy, ordering, flush and backpressure.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] INSTR = '0;
    logic [31:0] RA_DATA = '0;
    logic [31:0] RB_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  UNIT;
    logic [3:0]  FN;
    logic [4:0]  RC;
    logic        ILLEGAL;

    int n_checks = 0;
    int n_errors = 0;
    int n_out = 0;
    bit mon_en = 1'b0;
    logic [75:0] exp_q[$];

    alu_issue_stage dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR(INSTR), .RA_DATA(RA_DATA), .RB_DATA(RB_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .A(A), .B(B), .UNIT(UNIT), .FN(FN), .RC(RC), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // {legal, unit, fn} for opcode[3:0] in the 0x20-0x3F range.
    function automatic logic [6:0] op_table(input logic [3:0] low);
        case (low)
            4'h0: return 7'b1_00_0000;
            4'h1: return 7'b1_00_0001;
            4'h2: return 7'b1_00_0010;
            4'h3: return 7'b1_00_0011;
            4'h4: return 7'b1_01_0011;
            4'h5: return 7'b1_01_0101;
            4'h6: return 7'b1_01_0111;
            4'h8: return 7'b1_10_1000;
            4'h9: return 7'b1_10_1110;
            4'hA: return 7'b1_10_0110;
            4'hC: return 7'b1_11_0000;
            4'hD: return 7'b1_11_0001;
            4'hE: return 7'b1_11_0011;
            default: return 7'b0_10_0000;
        endcase
    endfunction

    function automatic logic [75:0] model(input logic [31:0] instr, input logic [31:0] ra,
                                          input logic [31:0] rb);
        logic [5:0]  op;
        logic [6:0]  t;
        logic [31:0] bb;
        op = instr[31:26];
        bb = op[4] ? {{16{instr[15]}}, instr[15:0]} : rb;
        t  = (op >= 6'h20) ? op_table(op[3:0]) : 7'b0_10_0000;
        return {ra, bb, t[5:4], t[3:0], instr[25:21], ~t[6]};
    endfunction

    // Model queue update at each edge: reset/flush empty it, else consume then accept.
    always @(posedge CLK) begin
        logic rdy;
        rdy = (exp_q.size() < CAP);
        if (RESET || FLUSH) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && OUT_READY) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            if (IN_VALID && rdy) exp_q.push_back(model(INSTR, RA_DATA, RB_DATA));
        end
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            n_checks++;
            if (OUT_VALID !== (exp_q.size() != 0)) begin
                n_errors++;
                $display("FAIL mon_out_valid t=%0t got=%b exp=%b", $time, OUT_VALID, exp_q.size() != 0);
            end
            n_checks++;
            if (IN_READY !== (exp_q.size() < CAP)) begin
                n_errors++;
                $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, IN_READY, exp_q.size() < CAP);
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                if ({A, B, UNIT, FN, RC, ILLEGAL} !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL mon_fields t=%0t got=%h exp=%h", $time,
                             {A, B, UNIT, FN, RC, ILLEGAL}, exp_q[0]);
                end
            end
        end
    end

    task automatic drive_one(input logic [31:0] instr, input logic [31:0] ra, input logic [31:0] rb);
        @(negedge CLK);
        IN_VALID = 1'b1; INSTR = instr; RA_DATA = ra; RB_DATA = rb;
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IN_VALID = 1'b1; INSTR = 32'hA4611000; RA_DATA = 32'h1234; RB_DATA = 32'h5678;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_errors++; $display("FAIL reset_hold_valid got=%b exp=0", OUT_VALID);
        end
        RESET = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({OUT_VALID, A, B, UNIT, FN, RC, ILLEGAL, IN_READY} !== {77'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_values got=%h exp=%h",
                     {OUT_VALID, A, B, UNIT, FN, RC, ILLEGAL, IN_READY}, {77'd0, 1'b1});
        end
        mon_en = 1'b1;
    endtask

    task automatic test_or_decode();
        OUT_READY = 1'b1;
        drive_one(32'hA4611000, 32'h0F0F0000, 32'h000000FF);
        n_checks++;
        if ({OUT_VALID, A, B, UNIT, FN, RC, ILLEGAL} !==
            {1'b1, 32'h0F0F0000, 32'h000000FF, 2'b10, 4'b1110, 5'd3, 1'b0}) begin
            n_errors++;
            $display("FAIL or_decode got=%h exp=%h", {OUT_VALID, A, B, UNIT, FN, RC, ILLEGAL},
                     {1'b1, 32'h0F0F0000, 32'h000000FF, 2'b10, 4'b1110, 5'd3, 1'b0});
        end
    endtask

    task automatic test_literal();
        logic [15:0] lits [2] = '{16'hFFF0, 16'h7FF0};
        logic [31:0] exp_b [2] = '{32'hFFFFFFF0, 32'h00007FF0};
        OUT_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_one({6'h38, 5'd7, 5'd1, lits[i]}, 32'hCAFE0000, 32'h11111111);
            n_checks++;
            if ({OUT_VALID, B, UNIT, FN, RC, ILLEGAL} !== {1'b1, exp_b[i], 2'b10, 4'b1000, 5'd7, 1'b0}) begin
                n_errors++;
                $display("FAIL literal_%0d got=%h exp=%h", i, {OUT_VALID, B, UNIT, FN, RC, ILLEGAL},
                         {1'b1, exp_b[i], 2'b10, 4'b1000, 5'd7, 1'b0});
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2] = '{6'h2B, 6'h18};
        logic [4:0] rcs [2] = '{5'd9, 5'd17};
        OUT_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_one({ops[i], rcs[i], 5'd1, 5'd2, 11'd0}, 32'h3, 32'h4);
            n_checks++;
            if ({OUT_VALID, UNIT, FN, RC, ILLEGAL} !== {1'b1, 2'b10, 4'b0000, rcs[i], 1'b1}) begin
                n_errors++;
                $display("FAIL illegal_%0d got=%h exp=%h", i, {OUT_VALID, UNIT, FN, RC, ILLEGAL},
                         {1'b1, 2'b10, 4'b0000, rcs[i], 1'b1});
            end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int base;
        bit go;
        @(negedge CLK);
        base = n_out;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge CLK);
            if (k == 2) begin
                n_checks++;
                if (sent != CAP) begin
                    n_errors++; $display("FAIL bp_accepted got=%0d exp=%0d", sent, CAP);
                end
            end
`ifdef ALU_ISSUE_SKID_EN
            if (k == 7) begin
                n_checks++;
                if (n_out - base != 4) begin
                    n_errors++; $display("FAIL bp_throughput got=%0d exp=4", n_out - base);
                end
            end
`endif
            OUT_READY = (k >= 3);
            go = (sent < 4) && (exp_q.size() < CAP);
            IN_VALID = (sent < 4);
            INSTR = {6'h20 + 6'(sent), 5'(sent + 1), 5'd2, 5'd3, 11'd0};
            RA_DATA = 32'h100 + 32'(sent);
            RB_DATA = 32'h200 + 32'(sent);
            @(posedge CLK);
            if (go) sent++;
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        n_checks++;
        if (n_out - base != 4) begin
            n_errors++; $display("FAIL bp_all_out got=%0d exp=4", n_out - base);
        end
    endtask

    task automatic test_flush();
        int guard = 0;
        @(negedge CLK);
        OUT_READY = 1'b0;
        while (exp_q.size() < CAP && guard < 10) begin
            IN_VALID = 1'b1;
            INSTR = {6'h30, 5'(guard + 4), 5'd1, 16'h0042};
            RA_DATA = 32'($urandom);
            @(negedge CLK);
            guard++;
        end
        FLUSH = 1'b1; IN_VALID = 1'b1; INSTR = {6'h21, 5'd30, 10'd0, 11'd0};
        @(negedge CLK);
        FLUSH = 1'b0; IN_VALID = 1'b0;
        n_checks++;
        if ({OUT_VALID, IN_READY} !== 2'b01) begin
            n_errors++; $display("FAIL flush_state got=%b exp=01", {OUT_VALID, IN_READY});
        end
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (OUT_VALID !== 1'b0) begin
                n_errors++; $display("FAIL flush_leak_%0d got=%b exp=0", i, OUT_VALID);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 31)) : 6'($urandom_range(32, 63));
            FLUSH     = ($urandom_range(0, 24) == 0);
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 2) != 0);
            INSTR     = {op, 26'($urandom)};
            RA_DATA   = 32'($urandom);
            RB_DATA   = 32'($urandom);
        end
        @(negedge CLK);
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        repeat (4) @(negedge CLK);
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_errors++; $display("FAIL drain_empty got=%b exp=0", OUT_VALID);
        end
    endtask

    initial begin
        test_reset();
        test_or_decode();
        test_literal();
        test_illegal();
        test_backpressure();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
